// File: rtl/pong_frame_renderer_if.sv
// Pixel bus between pong_frame_renderer and the LT24 driver.
//   master (renderer): drives xAddr, yAddr, pixelData, pixelWrite, frameStart;
//                      samples pixelReady
//   slave  (driver)  : samples the pixel, drives pixelReady
interface pong_frame_renderer_if;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        pixelReady;
  logic        frameStart;

  modport master (
    output xAddr, yAddr, pixelData, pixelWrite, frameStart,
    input  pixelReady
  );

  modport slave (
    input  xAddr, yAddr, pixelData, pixelWrite, frameStart,
    output pixelReady
  );
endinterface

// File: rtl/pong_frame_renderer.sv
// Pong frame renderer for the LT24 (240x320, RGB565).
// Runs its own raster scan, snapshots all object positions and the game state
// at the start of each frame, and renders through a 2-stage pipeline with
// pixelReady back-pressure. Also owns the START/PLAY/END game state machine.
//
// Ports:
//   clock, resetApp      clock and asynchronous active-high reset
//   playSwitch           game enable level
//   ballX/ballY          packed ball centres (8/9 bits per ball)
//   paddleX/paddleY      packed paddle centres (8/9 bits per paddle)
//   scores               packed player scores (8 bits per player)
//   pix                  pixel bus to the LT24 driver (master modport)
//   playFlag/resetFlag   live state is PLAY / START
//   winner               winning player index, valid in END
//
// Build option: define PONG_SCORE_BAR_EN to draw per-player score bars in PLAY.
//
// state    | meaning
// ST_START | game idle, screen black
// ST_PLAY  | game running, playfield rendered
// ST_END   | a player reached WIN_SCORE, winner banner shown
module pong_frame_renderer #(
  parameter int NUM_BALLS      = 2,
  parameter int NUM_PADDLES    = 2,
  parameter int BALL_SIZE      = 5,
  parameter int PADDLE_BREADTH = 5,
  parameter int PADDLE_LENGTH  = 15,
  parameter int WIN_SCORE      = 10,
  parameter int WALL_W         = 4,
  parameter int NET_Y          = 166
) (
  input  logic                     clock,
  input  logic                     resetApp,
  input  logic                     playSwitch,
  input  logic [8*NUM_BALLS-1:0]   ballX,
  input  logic [9*NUM_BALLS-1:0]   ballY,
  input  logic [8*NUM_PADDLES-1:0] paddleX,
  input  logic [9*NUM_PADDLES-1:0] paddleY,
  input  logic [8*NUM_PADDLES-1:0] scores,
  pong_frame_renderer_if.master    pix,
  output logic                     playFlag,
  output logic                     resetFlag,
  output logic [1:0]               winner
);

  localparam logic [7:0]  X_LAST      = 8'd239;
  localparam logic [8:0]  Y_LAST      = 9'd319;
  localparam logic [20:0] BALL_R2     = 21'(BALL_SIZE * BALL_SIZE);
  localparam logic [7:0]  WIN_SCORE_B = 8'(WIN_SCORE);

  typedef enum logic [1:0] {ST_START = 2'd0, ST_PLAY = 2'd1, ST_END = 2'd2} state_t;

  function automatic logic [15:0] objColour(input logic [1:0] idx);
    case (idx)
      2'd0:    objColour = 16'hF800;
      2'd1:    objColour = 16'h001F;
      2'd2:    objColour = 16'h07E0;
      default: objColour = 16'hFFE0;
    endcase
  endfunction

  // Magnitude of a signed 10-bit difference; operands are zero-extended, so
  // objects near the screen edge never wrap around.
  function automatic logic [9:0] absDiff(input logic [9:0] a, input logic [9:0] b);
    logic [9:0] d;
    d = a - b;
    absDiff = d[9] ? (10'd0 - d) : d;
  endfunction

  // ---------------- game state machine ----------------
  state_t     state, stateNext;
  logic [1:0] winnerNext;
  logic       anyWin;
  logic [1:0] winIdx;

  // Descending scan so the lowest winning index is the one left standing.
  always_comb begin
    anyWin = 1'b0;
    winIdx = 2'd0;
    for (int i = NUM_PADDLES - 1; i >= 0; i--) begin
      if (scores[8*i +: 8] >= WIN_SCORE_B) begin
        anyWin = 1'b1;
        winIdx = 2'(i);
      end
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state  <= ST_START;
      winner <= 2'd0;
    end else begin
      state  <= stateNext;
      winner <= winnerNext;
    end
  end

  always_comb begin
    stateNext  = state;
    winnerNext = winner;
    case (state)
      ST_START: if (playSwitch) stateNext = ST_PLAY;
      ST_PLAY: begin
        if (!playSwitch) begin
          stateNext = ST_START;
        end else if (anyWin) begin
          stateNext  = ST_END;
          winnerNext = winIdx;
        end
      end
      ST_END:   if (!playSwitch) stateNext = ST_START;
      default:  stateNext = ST_START;
    endcase
  end

  always_comb begin
    playFlag  = (state == ST_PLAY);
    resetFlag = (state == ST_START);
  end

  // ---------------- S0: scan counters and frame snapshot ----------------
  logic                     advance;
  logic                     frameWrap;
  logic [7:0]               xCnt;
  logic [8:0]               yCnt;
  logic [8*NUM_BALLS-1:0]   snapBallX;
  logic [9*NUM_BALLS-1:0]   snapBallY;
  logic [8*NUM_PADDLES-1:0] snapPadX;
  logic [9*NUM_PADDLES-1:0] snapPadY;
  state_t                   snapState;
  logic [1:0]               snapWinner;

  assign advance   = pix.pixelReady | ~pix.pixelWrite;
  assign frameWrap = advance && (xCnt == X_LAST) && (yCnt == Y_LAST);

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      xCnt       <= 8'd0;
      yCnt       <= 9'd0;
      snapBallX  <= '0;
      snapBallY  <= '0;
      snapPadX   <= '0;
      snapPadY   <= '0;
      snapState  <= ST_START;
      snapWinner <= 2'd0;
    end else if (advance) begin
      if (xCnt == X_LAST) begin
        xCnt <= 8'd0;
        yCnt <= (yCnt == Y_LAST) ? 9'd0 : yCnt + 9'd1;
      end else begin
        xCnt <= xCnt + 8'd1;
      end
      // Latch on the step into (0,0) so the whole next frame sees one view.
      if (frameWrap) begin
        snapBallX  <= ballX;
        snapBallY  <= ballY;
        snapPadX   <= paddleX;
        snapPadY   <= paddleY;
        snapState  <= state;
        snapWinner <= winner;
      end
    end
  end

  logic [NUM_BALLS-1:0]   ballHit;
  logic [NUM_PADDLES-1:0] padHit;
  logic                   wallHit;

  always_comb begin : hitCalc
    logic [9:0]  adx, ady;
    logic [19:0] sqx, sqy;
    adx     = '0;
    ady     = '0;
    sqx     = '0;
    sqy     = '0;
    ballHit = '0;
    padHit  = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      adx = absDiff({2'b00, xCnt}, {2'b00, snapBallX[8*i +: 8]});
      ady = absDiff({1'b0, yCnt}, {1'b0, snapBallY[9*i +: 9]});
      sqx = 20'(adx) * 20'(adx);
      sqy = 20'(ady) * 20'(ady);
      ballHit[i] = (21'(sqx) + 21'(sqy)) <= BALL_R2;
    end
    for (int i = 0; i < NUM_PADDLES; i++) begin
      adx = absDiff({2'b00, xCnt}, {2'b00, snapPadX[8*i +: 8]});
      ady = absDiff({1'b0, yCnt}, {1'b0, snapPadY[9*i +: 9]});
      padHit[i] = (adx < 10'(PADDLE_BREADTH)) && (ady < 10'(PADDLE_LENGTH));
    end
    wallHit = (xCnt < 8'(WALL_W)) || ((yCnt >= 9'(NET_Y)) && (yCnt <= 9'(NET_Y + 3)));
  end

`ifdef PONG_SCORE_BAR_EN
  logic [8*NUM_PADDLES-1:0] snapScores;
  logic [NUM_PADDLES-1:0]   barHit;
  logic [NUM_PADDLES-1:0]   s1Bar;

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp)       snapScores <= '0;
    else if (frameWrap) snapScores <= scores;
  end

  always_comb begin : barCalc
    logic [7:0]  sc;
    logic [10:0] barEnd;
    sc     = '0;
    barEnd = '0;
    barHit = '0;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      sc     = (snapScores[8*i +: 8] > WIN_SCORE_B) ? WIN_SCORE_B : snapScores[8*i +: 8];
      barEnd = 11'(WALL_W) + {1'b0, sc, 2'b00};
      barHit[i] = (yCnt >= 9'(4 + 8*i)) && (yCnt <= 9'(7 + 8*i)) &&
                  (xCnt >= 8'(WALL_W)) && ({3'b000, xCnt} < barEnd);
    end
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp)     s1Bar <= '0;
    else if (advance) s1Bar <= barHit;
  end
`endif

  // ---------------- S1: registered hit flags ----------------
  logic                   s1Valid;
  logic [7:0]             s1X;
  logic [8:0]             s1Y;
  state_t                 s1State;
  logic [1:0]             s1Winner;
  logic                   s1Wall;
  logic [NUM_BALLS-1:0]   s1Ball;
  logic [NUM_PADDLES-1:0] s1Pad;

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      s1Valid  <= 1'b0;
      s1X      <= 8'd0;
      s1Y      <= 9'd0;
      s1State  <= ST_START;
      s1Winner <= 2'd0;
      s1Wall   <= 1'b0;
      s1Ball   <= '0;
      s1Pad    <= '0;
    end else if (advance) begin
      s1Valid  <= 1'b1;
      s1X      <= xCnt;
      s1Y      <= yCnt;
      s1State  <= snapState;
      s1Winner <= snapWinner;
      s1Wall   <= wallHit;
      s1Ball   <= ballHit;
      s1Pad    <= padHit;
    end
  end

  // ---------------- S2: priority resolve ----------------
  // Layers are painted lowest priority first; later assignments override.
  logic [15:0] pixelNext;

  always_comb begin
    pixelNext = 16'h0000;
    case (s1State)
      ST_PLAY: begin
        pixelNext = 16'hFFFF;
        for (int i = NUM_BALLS - 1; i >= 0; i--)
          if (s1Ball[i]) pixelNext = objColour(2'(i));
        for (int i = NUM_PADDLES - 1; i >= 0; i--)
          if (s1Pad[i]) pixelNext = objColour(2'(i));
`ifdef PONG_SCORE_BAR_EN
        for (int i = NUM_PADDLES - 1; i >= 0; i--)
          if (s1Bar[i]) pixelNext = objColour(2'(i));
`endif
        if (s1Wall) pixelNext = 16'h39E7;
      end
      ST_END: begin
        pixelNext = ((s1Y >= 9'd140) && (s1Y <= 9'd179)) ? objColour(s1Winner) : 16'hFFFF;
      end
      default: pixelNext = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      pix.pixelWrite <= 1'b0;
      pix.xAddr      <= 8'd0;
      pix.yAddr      <= 9'd0;
      pix.pixelData  <= 16'h0000;
    end else if (advance) begin
      pix.pixelWrite <= s1Valid;
      pix.xAddr      <= s1X;
      pix.yAddr      <= s1Y;
      pix.pixelData  <= pixelNext;
    end
  end

  assign pix.frameStart = pix.pixelWrite & pix.pixelReady &
                          (pix.xAddr == 8'd0) & (pix.yAddr == 9'd0);

endmodule

// File: doc/pong_frame_renderer.md
# pong_frame_renderer

Parametrised pixel generator for the Terasic LT24 (240×320, RGB565) that replaces per-object hard-coded drawing with N balls and M paddles. It runs its own raster scan counters and a 2-stage pipeline with `pixelReady` back-pressure. It snapshots object positions, scores and game state once per frame so frames never tear. It sits between the game-physics blocks (ball/paddle/score) and the LT24 driver, and also owns the start/play/end game state machine.

## Interface
- `NUM_BALLS`, 2, number of balls (1–4)
- `NUM_PADDLES`, 2, number of paddles/players (1–4)
- `BALL_SIZE`, 5, ball radius in pixels
- `PADDLE_BREADTH`, 5, paddle half-width in x
- `PADDLE_LENGTH`, 15, paddle half-length in y
- `WIN_SCORE`, 10, score that ends the game
- `WALL_W`, 4, left wall width in columns
- `NET_Y`, 166, first row of the 4-row horizontal net
- `clock` in 1: pixel/system clock
- `resetApp` in 1: reset, asynchronous, active-high; clock `clock`
- `playSwitch` in 1: game enable switch (synchronous level)
- `ballX` in 8·NUM_BALLS: packed ball centres x; ball i at [8i+7:8i]
- `ballY` in 9·NUM_BALLS: packed ball centres y
- `paddleX` in 8·NUM_PADDLES: packed paddle centres x
- `paddleY` in 9·NUM_PADDLES: packed paddle centres y
- `scores` in 8·NUM_PADDLES: packed player scores
- `pixelReady` in 1: driver accepts the current pixel
- `xAddr` out 8: pixel column
- `yAddr` out 9: pixel row
- `pixelData` out 16: RGB565 colour
- `pixelWrite` out 1: pixel valid
- `frameStart` out 1: one-cycle pulse when pixel (0,0) is presented and accepted
- `playFlag` out 1: high in PLAY
- `resetFlag` out 1: high in START
- `winner` out 2: index of winning player, valid in END

## Operation
- Raster: x counts 0..239, then wraps to 0 and increments y; y counts 0..319, then wraps to 0. The counters advance only when the pipeline advances.
- Snapshot: when the scan enters (0,0), the block latches `ballX/Y`, `paddleX/Y`, `scores` and the game state for the whole frame.
- State machine, evaluated every cycle; the result is used at the next snapshot:
  - START→PLAY when `playSwitch`=1.
  - PLAY→START when `playSwitch`=0. This takes priority over the win check.
  - PLAY→END when any `scores[i]` ≥ WIN_SCORE. `winner` is set to the lowest such i, so simultaneous wins resolve to the lowest index.
  - END→START when `playSwitch`=0.
  - Illegal state→START.
- `playFlag`/`resetFlag`/`winner` reflect the live state, not the snapshot.
- Pixel colour by snapshot state:
  - START: solid 0x0000.
  - END: rows 140–179 in the winner colour; all other rows 0xFFFF.
  - PLAY: layered composition, highest priority first:
    - Wall 0x39E7: x<WALL_W, or NET_Y≤y≤NET_Y+3.
    - Paddle i: |x−px|<PADDLE_BREADTH and |y−py|<PADDLE_LENGTH. The lowest paddle index wins on overlap.
    - Ball i: (x−bx)²+(y−by)² ≤ BALL_SIZE². The lowest ball index wins on overlap.
    - Background 0xFFFF.
- Object colour by index: 0=0xF800, 1=0x001F, 2=0x07E0, 3=0xFFE0.
- Arithmetic: differences are signed 10-bit, squares unsigned 20-bit, sum 21-bit. Objects near x=0 must not wrap; a paddle at px=2 covers x 0..6 only.

## Timing
- Pipeline:
  - S0 is the scan counter.
  - S1 registers all hit flags plus x, y and the snapshot state.
  - S2 resolves priority into `pixelData`/`xAddr`/`yAddr`.
  - Latency is 2 cycles from counter to output.
- Advance enable = `pixelReady` | ~`pixelWrite`. While `pixelReady`=0 with `pixelWrite`=1, all outputs and pipeline registers hold.
- `pixelWrite` goes to 1 on the second clock after reset release and stays 1.
- Reset values: `pixelWrite`=0, `pixelData`=0, `xAddr`=0, `yAddr`=0, `frameStart`=0, `playFlag`=0, `resetFlag`=1, `winner`=0, state=START, counters=(0,0), snapshot cleared.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). Scan restarts at (0,0); the first pixel after reset is (0,0).
- Input changes mid-frame have no effect until the next snapshot.

## Configuration
- `PONG_SCORE_BAR_EN` defined: in PLAY, player i's score bar occupies rows 4+8i..7+8i and columns WALL_W..WALL_W+4·min(score,WIN_SCORE)−1, in player colour. Its priority is below the wall and above paddles.
- Undefined: no score bar logic is compiled in, and scores only drive the state machine.

## Test plan
- Reset, `playSwitch`=0, `pixelReady`=1: first output is (0,0) with data 0x0000 two cycles after release. `frameStart` pulses once per 76800 accepted pixels.
- `playSwitch`=1, ball0 at (120,100), BALL_SIZE 5: pixel (125,100) is 0xF800, (126,100) is 0xFFFF, and (2,100) is 0x39E7.
- Paddle0 at (2,50): x=0..6 on row 50 are 0xF800, except x<4 which are 0x39E7. No pixel at x≥250 (wrap) is drawn.
- `scores`={10,10} in PLAY: END is entered, `winner`=0, and rows 140–179 are 0xF800 from the next frame. Dropping `playSwitch` returns to START with `resetFlag`=1.
- `pixelReady` held low 5 cycles mid-row: `xAddr`/`yAddr`/`pixelData` are stable. After release the sequence continues with no skipped or duplicated coordinate.
- Ball0 moved mid-frame from y=10 to y=300: the current frame shows it at y=10 only; the next frame shows it at y=300.
